// File: rtl/preload_sequencer_pkg.sv
// Shared types and defaults for the weight pre-load sequencer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package preload_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRELOAD = 2'd2,
        READY   = 2'd3
    } state_t;

    localparam int DEF_ROWS        = 8;
    localparam int DEF_COLS        = 8;
    localparam int DEF_RED_W       = 5;
    localparam int DEF_COMP_W      = 3;
    localparam int DEF_CPE_PER_COL = 3;

    // Width able to count 0..slots inclusive (a "full" fill level included).
    function automatic int slot_w(input int slots);
        return $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/preload_sequencer_comp_slot_table.sv
// Per-column compensation slot table: arrival-ordered capture, sticky overflow, indexed readout.
// Latency: capture lands 1 cycle after cap; readout is combinational from rd_sel.
// Backpressure: none; beats beyond the slot count drop their compensation and set overflow.
// Ports: clr wipes the table; cap+comp+row offer one beat; rd_en/rd_sel pick the slot shown on
//        rd_data (0 when rd_en is low); slot_row/slot_vld/overflow expose the table contents.
module comp_slot_table
    import preload_pkg::*;
#(
    parameter int  CPE_PER_COL = DEF_CPE_PER_COL,
    parameter int  COMP_W      = DEF_COMP_W,
    parameter int  ROW_W       = 3,
    localparam int SLOT_W      = slot_w(CPE_PER_COL)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         cap,
    input  logic [COMP_W-1:0]            comp,
    input  logic [ROW_W-1:0]             row,
    input  logic                         rd_en,
    input  logic [SLOT_W-1:0]            rd_sel,
    output logic [COMP_W-1:0]            rd_data,
    output logic [CPE_PER_COL*ROW_W-1:0] slot_row,
    output logic [CPE_PER_COL-1:0]       slot_vld,
    output logic                         overflow
);

    logic [CPE_PER_COL-1:0][COMP_W-1:0] comp_q;
    logic [SLOT_W-1:0]                  fill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            comp_q   <= '0;
            slot_row <= '0;
            slot_vld <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            comp_q   <= '0;
            slot_row <= '0;
            slot_vld <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else if (cap && (comp != '0)) begin
            if (fill < SLOT_W'(CPE_PER_COL)) begin
                for (int s = 0; s < CPE_PER_COL; s++) begin
                    if (fill == SLOT_W'(s)) begin
                        comp_q[s]                   <= comp;
                        slot_row[s*ROW_W +: ROW_W]  <= row;
                        slot_vld[s]                 <= 1'b1;
                    end
                end
                fill <= fill + 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Unused slots are held at zero, so an empty slot reads out as 0.
    always_comb begin
        rd_data = '0;
        for (int s = 0; s < CPE_PER_COL; s++) begin
            if (rd_en && (rd_sel == SLOT_W'(s))) begin
                rd_data = comp_q[s];
            end
        end
    end

endmodule

// File: rtl/preload_sequencer.sv
// Splits a column-major weight stream into reduced weights (to weight memory) and per-column
//   compensation tables, then shifts the tables serially into the compensation CPE chains.
// Latency: memory write 1 cycle after each accepted beat; PRELOAD lasts CPE_PER_COL cycles.
// Backpressure: w_ready is high for the whole LOAD phase only; beats outside LOAD are ignored.
// Ports: start (IDLE/READY only), w_valid/w_ready/w_data in; wmem_we/addr/data write port;
//        cw_valid/cw_data chain shift; crow_idx/crow_vld/overflow slot tables; busy/done status.
module preload_sequencer
    import preload_pkg::*;
#(
    parameter int  ROWS        = DEF_ROWS,
    parameter int  COLS        = DEF_COLS,
    parameter int  RED_W       = DEF_RED_W,
    parameter int  COMP_W      = DEF_COMP_W,
    parameter int  CPE_PER_COL = DEF_CPE_PER_COL,
    localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int ADDR_W      = $clog2(ROWS*COLS),
    localparam int WEIGHT_W    = RED_W + COMP_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [WEIGHT_W-1:0]               w_data,
    output logic                              wmem_we,
    output logic [ADDR_W-1:0]                 wmem_addr,
    output logic [RED_W-1:0]                  wmem_data,
    output logic                              cw_valid,
    output logic [COLS*COMP_W-1:0]            cw_data,
    output logic [COLS*CPE_PER_COL*ROW_W-1:0] crow_idx,
    output logic [COLS*CPE_PER_COL-1:0]       crow_vld,
    output logic [COLS-1:0]                   overflow,
    output logic                              busy,
    output logic                              done
);

    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SLOT_W = slot_w(CPE_PER_COL);

    state_t            state, state_nx;
    logic [ROW_W-1:0]  row_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic [SLOT_W-1:0] pre_cnt;
    logic [SLOT_W-1:0] rd_sel;
    logic              accept, last_beat, launch, pre_last;

    assign accept    = w_valid && (state == LOAD);
    assign last_beat = accept && (row_cnt == ROW_W'(ROWS-1)) && (col_cnt == COL_W'(COLS-1));
    assign launch    = start && ((state == IDLE) || (state == READY));
    assign pre_last  = (pre_cnt == SLOT_W'(CPE_PER_COL-1));
    // Highest slot goes out first so that slot0 ends up in the first CPE of the chain.
    assign rd_sel    = SLOT_W'(CPE_PER_COL-1) - pre_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        w_ready  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        cw_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                w_ready = 1'b1;
                busy    = 1'b1;
                if (last_beat) state_nx = PRELOAD;
            end
            PRELOAD: begin
                busy     = 1'b1;
                cw_valid = 1'b1;
                if (pre_last) state_nx = READY;
            end
            READY: begin
                done = 1'b1;
                if (start) state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
            pre_cnt <= '0;
        end else if (launch) begin
            row_cnt <= '0;
            col_cnt <= '0;
            pre_cnt <= '0;
        end else if (accept) begin
            if (row_cnt == ROW_W'(ROWS-1)) begin
                row_cnt <= '0;
                col_cnt <= col_cnt + 1'b1;
            end else begin
                row_cnt <= row_cnt + 1'b1;
            end
        end else if (state == PRELOAD) begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wmem_we   <= 1'b0;
            wmem_addr <= '0;
            wmem_data <= '0;
        end else begin
            wmem_we <= accept;
            if (accept) begin
                wmem_addr <= ADDR_W'(col_cnt) * ADDR_W'(ROWS) + ADDR_W'(row_cnt);
                wmem_data <= w_data[WEIGHT_W-1:COMP_W];
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        comp_slot_table #(
            .CPE_PER_COL (CPE_PER_COL),
            .COMP_W      (COMP_W),
            .ROW_W       (ROW_W)
        ) u_tab (
            .clk      (clk),
            .rst      (rst),
            .clr      (launch),
            .cap      (accept && (col_cnt == COL_W'(c))),
            .comp     (w_data[COMP_W-1:0]),
            .row      (row_cnt),
            .rd_en    (cw_valid),
            .rd_sel   (rd_sel),
            .rd_data  (cw_data[c*COMP_W +: COMP_W]),
            .slot_row (crow_idx[c*CPE_PER_COL*ROW_W +: CPE_PER_COL*ROW_W]),
            .slot_vld (crow_vld[c*CPE_PER_COL +: CPE_PER_COL]),
            .overflow (overflow[c])
        );
    end

endmodule

// File: tb/tb_preload_sequencer.sv
// Bench for preload_sequencer: random and directed weight loads checked against a table model.
// Latency: n/a. Backpressure: bench drives w_valid patterns (always, toggling, random).
module tb_preload_sequencer;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int RED_W  = 5;
    localparam int COMP_W = 3;
    localparam int CPE    = 3;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int WW     = RED_W + COMP_W;
    localparam int N      = ROWS * COLS;
    localparam int AW     = $clog2(N);

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       start = 1'b0;
    logic                       w_valid = 1'b0;
    logic [WW-1:0]              w_data = '0;
    logic                       w_ready;
    logic                       wmem_we;
    logic [AW-1:0]              wmem_addr;
    logic [RED_W-1:0]           wmem_data;
    logic                       cw_valid;
    logic [COLS*COMP_W-1:0]     cw_data;
    logic [COLS*CPE*ROW_W-1:0]  crow_idx;
    logic [COLS*CPE-1:0]        crow_vld;
    logic [COLS-1:0]            overflow;
    logic                       busy;
    logic                       done;

    preload_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .RED_W(RED_W), .COMP_W(COMP_W), .CPE_PER_COL(CPE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .wmem_we(wmem_we), .wmem_addr(wmem_addr), .wmem_data(wmem_data),
        .cw_valid(cw_valid), .cw_data(cw_data), .crow_idx(crow_idx), .crow_vld(crow_vld),
        .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WW-1:0]             pat [N];
    logic [AW+RED_W-1:0]       wr_q [$];
    logic [COLS*COMP_W-1:0]    cw_q [$];

    logic [COLS*CPE*ROW_W-1:0] m_idx;
    logic [COLS*CPE-1:0]       m_vld;
    logic [COLS-1:0]           m_ovf;
    logic [COLS*COMP_W-1:0]    m_cw [CPE];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Observed write and shift traffic, sampled away from the rising edge.
    always @(negedge clk) begin
        if (wmem_we)  wr_q.push_back({wmem_addr, wmem_data});
        if (cw_valid) cw_q.push_back(cw_data);
    end

    // Reference: walk each column's rows in order, keep the first CPE non-zero compensations,
    // flag any surplus; the chain sees the kept list last-to-first.
    task automatic build_model();
        m_idx = '0;
        m_vld = '0;
        m_ovf = '0;
        for (int k = 0; k < CPE; k++) m_cw[k] = '0;
        for (int c = 0; c < COLS; c++) begin
            int kept;
            kept = 0;
            for (int r = 0; r < ROWS; r++) begin
                logic [COMP_W-1:0] cp;
                cp = pat[c*ROWS + r][COMP_W-1:0];
                if (cp != 0) begin
                    if (kept < CPE) begin
                        m_vld[c*CPE + kept] = 1'b1;
                        m_idx[(c*CPE + kept)*ROW_W +: ROW_W] = ROW_W'(r);
                        m_cw[CPE-1-kept][c*COMP_W +: COMP_W] = cp;
                        kept++;
                    end else begin
                        m_ovf[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"}, {w_ready, wmem_we, wmem_addr, wmem_data, cw_valid, busy, done, overflow}, '0);
        check({tag, "_cw"},  cw_data,  '0);
        check({tag, "_idx"}, crow_idx, '0);
        check({tag, "_vld"}, crow_vld, '0);
    endtask

    // vmode: 0 valid always, 1 toggling, 2 random. abort_at >= 0 pulls reset after that many beats.
    task automatic run_load(input int vmode, input bit start_mid, input bit start_pre, input int abort_at);
        int idx;
        int cyc;
        bit v;
        idx = 0;
        cyc = 0;
        build_model();
        wr_q.delete();
        cw_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_entry", {busy, done, w_ready, overflow, crow_vld},
              {1'b1, 1'b0, 1'b1, {COLS{1'b0}}, {(COLS*CPE){1'b0}}});

        while (idx < N && cyc < 2000) begin
            if (abort_at >= 0 && idx == abort_at) begin
                rst     = 1'b0;
                w_valid = 1'b0;
                #1;
                check_zero_outputs("abort");
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            w_valid = v;
            w_data  = v ? pat[idx] : WW'($urandom);
            start   = start_mid && (idx == N/3);
            if (v && w_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("beats_taken", idx, N);
        check("wready_drop", {w_ready, busy}, 2'b01);

        // Stray beats and a start pulse during PRELOAD must be ignored.
        cyc = 0;
        while (!done && cyc < 50) begin
            w_valid = 1'b1;
            w_data  = WW'($urandom);
            start   = start_pre && busy && !w_ready && (cyc == 0);
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check("done_seen", done, 1'b1);
        repeat (3) @(negedge clk);
        w_valid = 1'b0;
        check("ready_state", {done, busy, w_ready, cw_valid}, 4'b1000);
        check("n_writes", wr_q.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < wr_q.size()) begin
                logic [WW-1:0] w;
                w = pat[i];
                check("wr", wr_q[i], {AW'(i), w[WW-1:COMP_W]});
            end
        end
        check("n_shift", cw_q.size(), CPE);
        for (int k = 0; k < CPE; k++) begin
            if (k < cw_q.size()) check("cw", cw_q[k], m_cw[k]);
        end
        check("crow_vld", crow_vld, m_vld);
        check("crow_idx", crow_idx, m_idx);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic fill_const(input logic [WW-1:0] w);
        for (int i = 0; i < N; i++) pat[i] = w;
    endtask

    task automatic fill_random(input int comp_pct);
        for (int i = 0; i < N; i++) begin
            logic [RED_W-1:0]  r;
            logic [COMP_W-1:0] c;
            r = RED_W'($urandom);
            c = ($urandom_range(0, 99) < comp_pct) ? COMP_W'($urandom) : '0;
            pat[i] = {r, c};
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b1;

        // All weights 0xF8: no compensations at all.
        fill_const(8'hF8);
        run_load(0, 1'b0, 1'b0, -1);

        // Column 2 carries three compensations; shift order 7,2,5.
        fill_const(8'hF8);
        pat[2*ROWS + 1] = 8'h05;
        pat[2*ROWS + 4] = 8'h0A;
        pat[2*ROWS + 6] = 8'h0F;
        run_load(2, 1'b0, 1'b0, -1);

        // Column 0 rows 0..4 carry comps 1..5: overflow; starts mid-LOAD/PRELOAD ignored.
        fill_random(0);
        for (int r = 0; r < 5; r++) begin
            logic [RED_W-1:0] up;
            up = RED_W'($urandom);
            pat[r] = {up, COMP_W'(r + 1)};
        end
        run_load(0, 1'b1, 1'b1, -1);

        // Reload from READY with toggling valid; entry check confirms overflow was cleared.
        fill_random(40);
        run_load(1, 1'b0, 1'b0, -1);

        // Reset after 20 beats, then a clean load.
        fill_random(60);
        run_load(0, 1'b0, 1'b0, 20);
        fill_random(25);
        run_load(2, 1'b0, 1'b0, -1);

        for (int t = 0; t < 3; t++) begin
            fill_random($urandom_range(10, 90));
            run_load(2, t[0], 1'b1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
